// File: rtl/alu_exec_cc.sv
// Execute-stage ALU wrapper for Y86-64 OPq instructions plus the local 64-bit adder.
//
// adder_64 ports:
//   a, b     : 64-bit addends
//   cin      : carry in (1 turns a + ~x into a subtraction)
//   sum      : a + b + cin, modulo 2^64
//
// alu_exec_cc ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/ready   : request handshake (in_ready = !out_valid | out_ready)
//   ifun             : 0 addq, 1 subq, 2 andq, 3 xorq, others invalid
//   val_a, val_b     : operands; result is val_b OP val_a
//   set_cc           : update ZF/SF/OF with this op's flags
//   cond_fn          : jXX/cmovXX condition, evaluated against the pre-op CC
//   out_valid/ready  : result handshake towards the memory stage
//   val_e, cnd       : registered result and condition outcome
//   out_err          : registered invalid-ifun flag
//   cc_zf/sf/of      : architectural condition-code register

module adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum
);
  assign sum = a + b + 64'(cin);
endmodule

module alu_exec_cc #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] val_a,
  input  logic [W-1:0] val_b,
  input  logic         set_cc,
  input  logic [3:0]   cond_fn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] val_e,
  output logic         cnd,
  output logic         out_err,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam int unsigned MSB = W - 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state;
  logic         accept;
  logic         is_sub;
  logic         op_ok;
  logic [W-1:0] add_b;
  logic [W-1:0] add_sum;
  logic [W-1:0] res;
  logic         f_zf;
  logic         f_sf;
  logic         f_of;
  logic         cnd_next;

  assign out_valid = (state == FULL);
  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;

  // Subtraction is val_b + ~val_a + 1 through the shared adder.
  assign is_sub = (ifun == 4'd1);
  assign add_b  = is_sub ? ~val_a : val_a;

  adder_64 u_adder (
    .a   (val_b),
    .b   (add_b),
    .cin (is_sub),
    .sum (add_sum)
  );

  // Result and flag generation for the op being offered this cycle.
  always_comb begin
    res   = '0;
    op_ok = 1'b1;
    f_of  = 1'b0;
    case (ifun)
      4'd0: begin
        res  = add_sum;
        f_of = (val_a[MSB] == val_b[MSB]) & (add_sum[MSB] != val_a[MSB]);
      end
      4'd1: begin
        res  = add_sum;
        f_of = (val_a[MSB] != val_b[MSB]) & (add_sum[MSB] != val_b[MSB]);
      end
      4'd2:    res = val_b & val_a;
      4'd3:    res = val_b ^ val_a;
      default: op_ok = 1'b0;
    endcase
    f_zf = (res == '0);
    f_sf = res[MSB];
  end

  // Condition evaluation uses the CC as it stands before this op commits.
  always_comb begin
    cnd_next = 1'b0;
    case (cond_fn)
      4'd0:    cnd_next = 1'b1;
      4'd1:    cnd_next = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    cnd_next = cc_sf ^ cc_of;
      4'd3:    cnd_next = cc_zf;
      4'd4:    cnd_next = ~cc_zf;
      4'd5:    cnd_next = ~(cc_sf ^ cc_of);
      4'd6:    cnd_next = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cnd_next = 1'b0;
    endcase
  end

  // Output register, CC register and EMPTY/FULL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      val_e   <= '0;
      cnd     <= 1'b0;
      out_err <= 1'b0;
      cc_zf   <= 1'b1;
      cc_sf   <= 1'b0;
      cc_of   <= 1'b0;
    end else if (accept) begin
      state   <= FULL;
      val_e   <= res;
      cnd     <= cnd_next;
      out_err <= ~op_ok;
      if (set_cc && op_ok) begin
        cc_zf <= f_zf;
        cc_sf <= f_sf;
        cc_of <= f_of;
      end
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_exec_cc.sv
// Scoreboarded bench for alu_exec_cc: directed ops with hand-computed results.
module tb_alu_exec_cc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        set_cc;
  logic [3:0]  cond_fn;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] val_e;
  logic        cnd;
  logic        out_err;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  typedef struct packed {
    logic [63:0] val;
    logic        cnd;
    logic        err;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_cc #(.W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .set_cc    (set_cc),
    .cond_fn   (cond_fn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .cnd       (cnd),
    .out_err   (out_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Push the expected response, then hold the request until it is accepted.
  task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic sc, input logic [3:0] cf, input logic [63:0] ev,
                       input logic ec, input logic ee, input logic ez, input logic es,
                       input logic eo);
    int n;
    exp_t e;
    e.val = ev; e.cnd = ec; e.err = ee; e.zf = ez; e.sf = es; e.of = eo;
    sb.push_back(e);
    ifun = f; val_a = a; val_b = b; set_cc = sc; cond_fn = cf;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every consumed result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output actual=%h required=none", val_e);
        end else begin
          e = sb.pop_front();
          chk("val_e",   val_e,        e.val);
          chk("cnd",     64'(cnd),     64'(e.cnd));
          chk("out_err", 64'(out_err), 64'(e.err));
          chk("cc_zf",   64'(cc_zf),   64'(e.zf));
          chk("cc_sf",   64'(cc_sf),   64'(e.sf));
          chk("cc_of",   64'(cc_of),   64'(e.of));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; ifun = 4'd0; val_a = '0; val_b = '0;
    set_cc = 1'b0; cond_fn = 4'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_val_e",     val_e,          64'd0);
    chk("rst_zf",        64'(cc_zf),     64'd1);
    chk("rst_sf",        64'(cc_sf),     64'd0);
    chk("rst_of",        64'(cc_of),     64'd0);
    @(posedge clk);
    #1;

    // Back-to-back ops:     ifun  a                      b      sc  cf    val_e                  c  e  z  s  o
    issue(4'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b1, 4'd0, 64'h8000000000000000, 1, 0, 0, 1, 1);
    issue(4'd1, 64'd5,               64'd5, 1'b1, 4'd0, 64'd0,               1, 0, 1, 0, 0);
    issue(4'd2, 64'hF0,              64'hFF, 1'b0, 4'd3, 64'hF0,             1, 0, 1, 0, 0);
    issue(4'd1, 64'd1,               64'd0, 1'b1, 4'd4, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 1, 0);
    issue(4'd0, 64'd1,               64'd2, 1'b0, 4'd2, 64'd3,               1, 0, 0, 1, 0);
    issue(4'd1, 64'h8000000000000000, 64'd0, 1'b1, 4'd5, 64'h8000000000000000, 0, 0, 0, 1, 1);
    issue(4'd3, 64'hAAAA,            64'hAAAA, 1'b1, 4'd6, 64'd0,            1, 0, 1, 0, 0);
    issue(4'd7, 64'd3,               64'd4, 1'b1, 4'd1, 64'd0,               1, 1, 1, 0, 0);
    issue(4'd0, 64'd0,               64'd0, 1'b0, 4'd7, 64'd0,               0, 0, 1, 0, 0);

    // Backpressure: result 5 held for 3 cycles while an xorq waits.
    issue(4'd0, 64'd2, 64'd3, 1'b1, 4'd0, 64'd5, 1, 0, 0, 0, 0);
    out_ready = 1'b0;
    e.val = 64'hF0; e.cnd = 1'b0; e.err = 1'b0; e.zf = 1'b0; e.sf = 1'b0; e.of = 1'b0;
    sb.push_back(e);
    ifun = 4'd3; val_a = 64'hFF; val_b = 64'h0F; set_cc = 1'b1; cond_fn = 4'd3;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready",  64'(in_ready),  64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_val_e",     val_e,          64'd5);
      chk("stall_cc", 64'({cc_zf, cc_sf, cc_of}), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_out_valid", 64'(out_valid), 64'd1);

    // Let the scoreboard drain.
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Reset while FULL and stalled discards the result and restores the CC.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1; ifun = 4'd0; val_a = 64'd1; val_b = 64'd1; set_cc = 1'b1; cond_fn = 4'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_full", 64'(out_valid), 64'd1);
    chk("pre_rst_val",  val_e,          64'd2);
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_val_e",     val_e,          64'd0);
    chk("post_rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'd4);
    chk("post_rst_err",       64'(out_err),   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
